fifo_ptr_ctrl: RTL and testbench

Pointer, occupancy and byte-lane controller for the longword DMA FIFO. It sits directly downstream of the CPU state machine output decode and consumes its registered FIFO strobes: increment/decrement FIFO, advance next-in, advance next-out. It also consumes the SCSI-side byte-advance strobe. From these it maintains the FIFO read/write pointers, the byte pointer and the occupancy count. It returns full/empty/half flags to the CPU and SCSI state machines.

---
 rtl/fifo_ptr_ctrl_pkg.sv | 12 +
 rtl/fifo_ptr_ctrl_if.sv | 37 +++
 rtl/fifo_ptr_ctrl_wrap_ctr.sv | 21 ++
 rtl/fifo_ptr_ctrl.sv | 87 ++++++++
 tb/tb_fifo_ptr_ctrl.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_ptr_ctrl_pkg.sv
// Shared sizing constants and types for the longword DMA FIFO pointer controller.
package fifo_ctrl_pkg;

  localparam int DEPTH_LOG2 = 3;
  localparam int FIFO_DEPTH = 1 << DEPTH_LOG2;
  localparam int HALF_MARK  = FIFO_DEPTH / 2;

  typedef logic [DEPTH_LOG2-1:0] ptr_t;
  typedef logic [DEPTH_LOG2:0]   cnt_t;
  typedef logic [1:0]            bptr_t;

endpackage

// File: rtl/fifo_ptr_ctrl_if.sv
// Strobe and status bundle between the CPU/SCSI state machines (master) and the
// pointer controller (slave).
interface fifo_ptr_ctrl_if #(
  parameter int DEPTH_LOG2 = fifo_ctrl_pkg::DEPTH_LOG2
);

  logic                  FLUSH;
  logic                  INCFIFO;
  logic                  DECFIFO;
  logic                  INCNI;
  logic                  INCNO;
  logic                  INCBO;
  logic                  ERR_CLR;
  logic [DEPTH_LOG2-1:0] NI_PTR;
  logic [DEPTH_LOG2-1:0] NO_PTR;
  logic [1:0]            BO_PTR;
  logic                  BO_LAST;
  logic [DEPTH_LOG2:0]   COUNT;
  logic                  FIFOFULL;
  logic                  FIFOEMPTY;
  logic                  FIFOHALF;
  logic                  OVF;
  logic                  UNF;

  modport master (
    output FLUSH, INCFIFO, DECFIFO, INCNI, INCNO, INCBO, ERR_CLR,
    input  NI_PTR, NO_PTR, BO_PTR, BO_LAST, COUNT,
    input  FIFOFULL, FIFOEMPTY, FIFOHALF, OVF, UNF
  );

  modport slave (
    input  FLUSH, INCFIFO, DECFIFO, INCNI, INCNO, INCBO, ERR_CLR,
    output NI_PTR, NO_PTR, BO_PTR, BO_LAST, COUNT,
    output FIFOFULL, FIFOEMPTY, FIFOHALF, OVF, UNF
  );

endinterface

// File: rtl/fifo_ptr_ctrl_wrap_ctr.sv
// Free-running modulo-2^W counter with sync reset and clear; one-cycle update,
// never stalls.
module wrap_ctr #(
  parameter int W = 3
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         CLR,
  input  logic         INC,
  output logic [W-1:0] Q
);

  always_ff @(posedge CLK) begin
    if (RST || CLR) begin
      Q <= '0;
    end else if (INC) begin
      Q <= Q + 1'b1;
    end
  end

endmodule

// File: rtl/fifo_ptr_ctrl.sv
// Read/write/byte pointers, occupancy count and sticky OVF/UNF for the DMA FIFO.
// Strobes update state at the next edge; flags decode registered state; no backpressure.
module fifo_ptr_ctrl #(
  parameter int DEPTH_LOG2 = fifo_ctrl_pkg::DEPTH_LOG2
) (
  input logic           CLK,
  input logic           RST,
  fifo_ptr_ctrl_if.slave bus
);

  localparam int                  DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] CNT_FULL = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] CNT_HALF = (DEPTH_LOG2+1)'(DEPTH / 2);

  logic [DEPTH_LOG2-1:0] ni_ptr;
  logic [DEPTH_LOG2-1:0] no_ptr;
  logic [1:0]            bo_ptr;
  logic [DEPTH_LOG2:0]   count;
  logic [DEPTH_LOG2:0]   count_nxt;
  logic                  ovf;
  logic                  unf;
  logic                  ovf_evt;
  logic                  unf_evt;
  logic                  full;
  logic                  empty;

  wrap_ctr #(.W(DEPTH_LOG2)) u_ni_ctr (
    .CLK (CLK), .RST (RST), .CLR (bus.FLUSH), .INC (bus.INCNI), .Q (ni_ptr)
  );

  wrap_ctr #(.W(DEPTH_LOG2)) u_no_ctr (
    .CLK (CLK), .RST (RST), .CLR (bus.FLUSH), .INC (bus.INCNO), .Q (no_ptr)
  );

  wrap_ctr #(.W(2)) u_bo_ctr (
    .CLK (CLK), .RST (RST), .CLR (bus.FLUSH), .INC (bus.INCBO), .Q (bo_ptr)
  );

  assign full  = (count == CNT_FULL);
  assign empty = (count == '0);

  // Simultaneous INCFIFO and DECFIFO cancel, so they never raise an error even at the limits.
  always_comb begin
    count_nxt = count;
    ovf_evt   = 1'b0;
    unf_evt   = 1'b0;
    if (bus.INCFIFO && !bus.DECFIFO) begin
      if (full) begin
        ovf_evt = 1'b1;
      end else begin
        count_nxt = count + 1'b1;
      end
    end else if (bus.DECFIFO && !bus.INCFIFO) begin
      if (empty) begin
        unf_evt = 1'b1;
      end else begin
        count_nxt = count - 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      count <= '0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else if (bus.FLUSH) begin
      count <= '0;
    end else begin
      count <= count_nxt;
      ovf   <= ovf_evt | (ovf & ~bus.ERR_CLR);
      unf   <= unf_evt | (unf & ~bus.ERR_CLR);
    end
  end

  assign bus.NI_PTR    = ni_ptr;
  assign bus.NO_PTR    = no_ptr;
  assign bus.BO_PTR    = bo_ptr;
  assign bus.BO_LAST   = (bo_ptr == 2'd3);
  assign bus.COUNT     = count;
  assign bus.FIFOFULL  = full;
  assign bus.FIFOEMPTY = empty;
  assign bus.FIFOHALF  = (count >= CNT_HALF);
  assign bus.OVF       = ovf;
  assign bus.UNF       = unf;

endmodule

// File: tb/tb_fifo_ptr_ctrl.sv
// Self-checking bench for fifo_ptr_ctrl: behavioural model feeds a scoreboard queue,
// each scenario task also checks the fixed values it is built to reach.
module tb_fifo_ptr_ctrl;
  import fifo_ctrl_pkg::*;

  localparam logic [7:0] S_RST   = 8'h80;
  localparam logic [7:0] S_FLUSH = 8'h40;
  localparam logic [7:0] S_INCF  = 8'h20;
  localparam logic [7:0] S_DECF  = 8'h10;
  localparam logic [7:0] S_INCNI = 8'h08;
  localparam logic [7:0] S_INCNO = 8'h04;
  localparam logic [7:0] S_INCBO = 8'h02;
  localparam logic [7:0] S_ERRC  = 8'h01;

  typedef struct packed {
    cnt_t  count;
    ptr_t  ni;
    ptr_t  no;
    bptr_t bo;
    logic  bo_last;
    logic  full;
    logic  empty;
    logic  half;
    logic  ovf;
    logic  unf;
  } obs_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fifo_ptr_ctrl_if #(.DEPTH_LOG2(DEPTH_LOG2)) bus ();

  fifo_ptr_ctrl #(.DEPTH_LOG2(DEPTH_LOG2)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  int   n_tests = 0;
  int   n_fail  = 0;
  int   m_count = 0, m_ni = 0, m_no = 0, m_bo = 0;
  logic m_ovf = 1'b0, m_unf = 1'b0;
  obs_t sb[$];

  function automatic obs_t mk(int cnt, int ni, int no, int bo, logic ovf, logic unf);
    obs_t o;
    o.count   = cnt_t'(cnt);
    o.ni      = ptr_t'(ni);
    o.no      = ptr_t'(no);
    o.bo      = bptr_t'(bo);
    o.bo_last = (bo == 3);
    o.full    = (cnt == FIFO_DEPTH);
    o.empty   = (cnt == 0);
    o.half    = (cnt >= HALF_MARK);
    o.ovf     = ovf;
    o.unf     = unf;
    return o;
  endfunction

  function automatic obs_t observe();
    obs_t o;
    o.count   = bus.COUNT;
    o.ni      = bus.NI_PTR;
    o.no      = bus.NO_PTR;
    o.bo      = bus.BO_PTR;
    o.bo_last = bus.BO_LAST;
    o.full    = bus.FIFOFULL;
    o.empty   = bus.FIFOEMPTY;
    o.half    = bus.FIFOHALF;
    o.ovf     = bus.OVF;
    o.unf     = bus.UNF;
    return o;
  endfunction

  // Drive one cycle of strobes, push the model's prediction, then advance past the edge.
  task automatic apply(input logic [7:0] s);
    logic ovf_evt, unf_evt;
    rst         = s[7];
    bus.FLUSH   = s[6];
    bus.INCFIFO = s[5];
    bus.DECFIFO = s[4];
    bus.INCNI   = s[3];
    bus.INCNO   = s[2];
    bus.INCBO   = s[1];
    bus.ERR_CLR = s[0];
    if (s[7]) begin
      m_count = 0; m_ni = 0; m_no = 0; m_bo = 0; m_ovf = 1'b0; m_unf = 1'b0;
    end else if (s[6]) begin
      m_count = 0; m_ni = 0; m_no = 0; m_bo = 0;
    end else begin
      ovf_evt = s[5] && !s[4] && (m_count == FIFO_DEPTH);
      unf_evt = s[4] && !s[5] && (m_count == 0);
      if (s[5] && !s[4] && !ovf_evt) m_count++;
      if (s[4] && !s[5] && !unf_evt) m_count--;
      m_ni  = (m_ni + int'(s[3])) % FIFO_DEPTH;
      m_no  = (m_no + int'(s[2])) % FIFO_DEPTH;
      m_bo  = (m_bo + int'(s[1])) % 4;
      m_ovf = ovf_evt || (m_ovf && !s[0]);
      m_unf = unf_evt || (m_unf && !s[0]);
    end
    sb.push_back(mk(m_count, m_ni, m_no, m_bo, m_ovf, m_unf));
    @(posedge clk);
    #1;
    rst = 1'b0;
    {bus.FLUSH, bus.INCFIFO, bus.DECFIFO, bus.INCNI, bus.INCNO, bus.INCBO, bus.ERR_CLR} = '0;
  endtask

  task automatic test_reset();
    obs_t got, exp;
    apply(S_RST);
    exp = sb.pop_front();
    got = observe();
    n_tests++;
    if (got !== exp) begin
      n_fail++; $display("FAIL reset_sb: got %h expected %h", got, exp);
    end
    n_tests++;
    if (got !== mk(0, 0, 0, 0, 1'b0, 1'b0)) begin
      n_fail++; $display("FAIL reset_values: got %h expected %h", got, mk(0, 0, 0, 0, 1'b0, 1'b0));
    end
  endtask

  task automatic test_fill();
    obs_t got, exp;
    for (int i = 0; i < 8; i++) begin
      apply(S_INCF | S_INCNI);
      exp = sb.pop_front(); got = observe(); n_tests++;
      if (got !== exp) begin
        n_fail++; $display("FAIL fill step %0d: got %h expected %h", i, got, exp);
      end
    end
    n_tests++;
    if (observe() !== mk(8, 0, 0, 0, 1'b0, 1'b0)) begin
      n_fail++; $display("FAIL fill_full: got %h expected %h", observe(), mk(8, 0, 0, 0, 1'b0, 1'b0));
    end
    apply(S_INCF);
    exp = sb.pop_front(); got = observe(); n_tests++;
    if (got !== exp || got.count !== cnt_t'(8) || got.ovf !== 1'b1) begin
      n_fail++; $display("FAIL fill_overflow: got %h expected %h", got, exp);
    end
    // A fresh overflow in the same cycle as ERR_CLR must leave OVF set.
    apply(S_INCF | S_ERRC);
    exp = sb.pop_front(); got = observe(); n_tests++;
    if (got !== exp || got.ovf !== 1'b1) begin
      n_fail++; $display("FAIL errclr_vs_ovf: got %h expected %h", got, exp);
    end
  endtask

  task automatic test_drain();
    obs_t got, exp;
    for (int i = 0; i < 8; i++) begin
      apply(S_DECF | S_INCNO);
      exp = sb.pop_front(); got = observe(); n_tests++;
      if (got !== exp) begin
        n_fail++; $display("FAIL drain step %0d: got %h expected %h", i, got, exp);
      end
    end
    got = observe(); n_tests++;
    if (got.count !== cnt_t'(0) || got.empty !== 1'b1 || got.no !== ptr_t'(0) || got.unf !== 1'b0) begin
      n_fail++; $display("FAIL drain_empty: got %h", got);
    end
    apply(S_DECF);
    exp = sb.pop_front(); got = observe(); n_tests++;
    if (got !== exp || got.count !== cnt_t'(0) || got.unf !== 1'b1) begin
      n_fail++; $display("FAIL drain_underflow: got %h expected %h", got, exp);
    end
  endtask

  task automatic test_simultaneous();
    obs_t got, exp;
    apply(S_RST);
    void'(sb.pop_front());
    for (int i = 0; i < 3; i++) begin
      apply(S_INCF);
      void'(sb.pop_front());
    end
    for (int i = 0; i < 5; i++) begin
      apply(S_INCF | S_DECF);
      exp = sb.pop_front(); got = observe(); n_tests++;
      if (got !== exp || got.count !== cnt_t'(3)) begin
        n_fail++; $display("FAIL both_at_3 cycle %0d: got %h expected %h", i, got, exp);
      end
    end
    for (int i = 0; i < 5; i++) begin
      apply(S_INCF);
      void'(sb.pop_front());
    end
    for (int i = 0; i < 2; i++) begin
      apply(S_INCF | S_DECF);
      exp = sb.pop_front(); got = observe(); n_tests++;
      if (got !== exp || got.count !== cnt_t'(8) || got.ovf !== 1'b0) begin
        n_fail++; $display("FAIL both_at_full cycle %0d: got %h expected %h", i, got, exp);
      end
    end
  endtask

  task automatic test_byte_ptr();
    obs_t got, exp;
    int   seq [5] = '{1, 2, 3, 0, 1};
    for (int i = 0; i < 5; i++) begin
      apply(S_INCBO);
      exp = sb.pop_front(); got = observe(); n_tests++;
      if (got !== exp || got.bo !== bptr_t'(seq[i]) || got.bo_last !== (seq[i] == 3)) begin
        n_fail++; $display("FAIL byte_ptr step %0d: got bo=%0d last=%b expected bo=%0d", i, got.bo, got.bo_last, seq[i]);
      end
    end
  endtask

  task automatic test_flush();
    obs_t got, exp;
    apply(S_RST);
    void'(sb.pop_front());
    for (int i = 0; i < 5; i++) begin apply(S_INCF | S_INCNI); void'(sb.pop_front()); end
    for (int i = 0; i < 4; i++) begin apply(S_INCF); void'(sb.pop_front()); end
    for (int i = 0; i < 3; i++) begin apply(S_DECF); void'(sb.pop_front()); end
    apply(S_INCBO);
    exp = sb.pop_front(); got = observe(); n_tests++;
    if (got !== mk(5, 5, 0, 1, 1'b1, 1'b0)) begin
      n_fail++; $display("FAIL flush_setup: got %h expected %h", got, mk(5, 5, 0, 1, 1'b1, 1'b0));
    end
    apply(S_FLUSH | S_INCF | S_INCNI | S_INCBO);
    exp = sb.pop_front(); got = observe(); n_tests++;
    if (got !== exp || got !== mk(0, 0, 0, 0, 1'b1, 1'b0)) begin
      n_fail++; $display("FAIL flush_clear: got %h expected %h", got, mk(0, 0, 0, 0, 1'b1, 1'b0));
    end
    apply(S_ERRC);
    exp = sb.pop_front(); got = observe(); n_tests++;
    if (got !== exp || got.ovf !== 1'b0) begin
      n_fail++; $display("FAIL flush_errclr: got %h expected %h", got, exp);
    end
  endtask

  task automatic test_mid_reset();
    obs_t got, exp;
    for (int i = 0; i < 4; i++) begin apply(S_INCF | S_INCNO); void'(sb.pop_front()); end
    apply(S_DECF);
    void'(sb.pop_front());
    apply(S_DECF);
    void'(sb.pop_front());
    apply(S_INCF | S_INCF);
    void'(sb.pop_front());
    apply(S_INCF);
    exp = sb.pop_front(); got = observe(); n_tests++;
    if (got !== exp || got.count !== cnt_t'(4) || got.half !== 1'b1) begin
      n_fail++; $display("FAIL mid_reset_setup: got %h expected %h", got, exp);
    end
    apply(S_RST | S_INCF | S_INCNI | S_INCBO);
    exp = sb.pop_front(); got = observe(); n_tests++;
    if (got !== exp || got !== mk(0, 0, 0, 0, 1'b0, 1'b0)) begin
      n_fail++; $display("FAIL mid_reset: got %h expected %h", got, mk(0, 0, 0, 0, 1'b0, 1'b0));
    end
  endtask

  initial begin
    rst = 1'b1;
    {bus.FLUSH, bus.INCFIFO, bus.DECFIFO, bus.INCNI, bus.INCNO, bus.INCBO, bus.ERR_CLR} = '0;
    test_reset();
    test_fill();
    test_drain();
    test_simultaneous();
    test_byte_ptr();
    test_flush();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
